// File: rtl/demux4_stream.sv
// demux4_stream: 1-to-4 valid/ready stream demultiplexer.
// Each accepted word goes into a one-entry registered holding stage for the
// channel chosen by in_sel. Channels drain independently, so a stalled
// consumer only blocks words addressed to it.
// Optional build macro: DEMUX4_STATS_EN adds saturating per-channel beat
// counters on the beat_cnt port.
module demux4_stream #(
   parameter int WIDTH = 12,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [1:0]           in_sel,
   output logic [3:0]           out_valid,
   input  logic [3:0]           out_ready,
   output logic [4*WIDTH-1:0]   out_data
`ifdef DEMUX4_STATS_EN
   ,
   output logic [4*CNT_W-1:0]   beat_cnt
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Reject nonsensical widths at elaboration.
   if (WIDTH < 1 || CNT_W < 1) begin : g_bad_params
      $error("demux4_stream: WIDTH and CNT_W must be at least 1");
   end

   logic acc;

   // The selected channel can take a word if it is empty or draining this
   // cycle; held low during reset so nothing is accepted then.
   assign in_ready = rst_n & (~out_valid[in_sel] | out_ready[in_sel]);
   assign acc      = in_valid & in_ready;

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_chan
      state_t            state_reg;
      state_t            state_next;
      logic [WIDTH-1:0]  data_reg;
      logic              ld;
      logic              dr;

      assign ld = acc & (in_sel == 2'(gi));
      assign dr = (state_reg == FULL) & out_ready[gi];

      assign out_valid[gi]                = (state_reg == FULL);
      assign out_data[gi*WIDTH +: WIDTH]  = data_reg;

      // Channel state register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_reg <= EMPTY;
         end else begin
            state_reg <= state_next;
         end
      end

      // Next-state: load fills, drain without reload empties.
      always_comb begin
         state_next = state_reg;
         case (state_reg)
            EMPTY: if (ld) state_next = FULL;
            FULL:  if (dr && !ld) state_next = EMPTY;
            default: state_next = EMPTY;
         endcase
      end

      // Holding register; keeps its last value after a drain.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_reg <= '0;
         end else if (ld) begin
            data_reg <= in_data;
         end
      end

`ifdef DEMUX4_STATS_EN
      logic [CNT_W-1:0] cnt_reg;

      assign beat_cnt[gi*CNT_W +: CNT_W] = cnt_reg;

      // Saturating count of words loaded into this channel.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_reg <= '0;
         end else if (ld && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
`endif
   end

endmodule

// File: tb/tb_demux4_stream.sv
// Directed testbench for demux4_stream with a per-channel scoreboard:
// accepted words are queued per channel and compared when drained.
module tb_demux4_stream;
   localparam int WIDTH = 12;
   localparam int CNT_W = 4;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic [1:0]           in_sel;
   logic [3:0]           out_valid;
   logic [3:0]           out_ready;
   logic [4*WIDTH-1:0]   out_data;
`ifdef DEMUX4_STATS_EN
   logic [4*CNT_W-1:0]   beat_cnt;
`endif

   demux4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef DEMUX4_STATS_EN
      ,
      .beat_cnt  (beat_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;
   int n_acc = 0;
   logic [WIDTH-1:0] q [4][$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] chan_data(input int k);
      return out_data[k*WIDTH +: WIDTH];
   endfunction

   function automatic logic [3:0] model_valid();
      logic [3:0] v;
      for (int k = 0; k < 4; k++) v[k] = (q[k].size() != 0);
      return v;
   endfunction

   // One clock: check state and ready against the model, score handshakes,
   // then advance past the rising edge. Inputs are set by the caller.
   task automatic cycle();
      logic exp_ready;
      #1;
      chk("out_valid", out_valid, model_valid());
      exp_ready = rst_n & (!(q[in_sel].size() != 0) | out_ready[in_sel]);
      chk("in_ready", in_ready, exp_ready);
      for (int k = 0; k < 4; k++) begin
         if (out_valid[k] && out_ready[k] && q[k].size() != 0) begin
            chk($sformatf("drain_ch%0d", k), chan_data(k), q[k][0]);
            void'(q[k].pop_front());
         end
      end
      if (in_valid && in_ready) begin
         q[in_sel].push_back(in_data);
         n_acc++;
         $display("accept sel=%0d data=0x%03h", in_sel, in_data);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = '0;
      out_ready = 4'b0000;
      #12;
      chk("rst_out_valid", out_valid, 4'b0000);
      chk("rst_out_data", out_data, '0);
      chk("rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1: single word to channel 2, held while stalled.
      drive(1'b1, 2'd2, 12'hABC);
      cycle();
      drive(1'b0, 2'd0, 12'h000);
      chk("t1_valid", out_valid, 4'b0100);
      chk("t1_data2", chan_data(2), 12'hABC);
      for (int i = 0; i < 5; i++) cycle();
      chk("t1_hold_data2", chan_data(2), 12'hABC);

      // 2: channel 1 full and stalled blocks a new word until ready rises.
      drive(1'b1, 2'd1, 12'h0A1);
      cycle();
      drive(1'b1, 2'd1, 12'h111);
      #1;
      chk("t2_blocked_ready", in_ready, 1'b0);
      cycle();
      chk("t2_old_word", chan_data(1), 12'h0A1);
      out_ready = 4'b0010;
      cycle();
      drive(1'b0, 2'd0, 12'h000);
      out_ready = 4'b0000;
      chk("t2_new_word", chan_data(1), 12'h111);
      out_ready = 4'b1111;
      for (int i = 0; i < 2; i++) cycle();
      chk("t2_drained", out_valid, 4'b0000);

      // 3: back-to-back stream to channel 3 at full rate.
      out_ready = 4'b1000;
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 2'd3, WIDTH'(i));
         #1;
         chk("t3_ready", in_ready, 1'b1);
         cycle();
         chk("t3_latency", chan_data(3), WIDTH'(i));
      end
      drive(1'b0, 2'd0, 12'h000);
      cycle();
      chk("t3_empty", out_valid, 4'b0000);

      // 4: channel 0 stalled full; other channels stream freely.
      out_ready = 4'b0000;
      drive(1'b1, 2'd0, 12'h0C0);
      cycle();
      out_ready = 4'b1110;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 2'(1 + (i % 3)), WIDTH'(12'h200 + i));
         #1;
         chk("t4_no_stall", in_ready, 1'b1);
         cycle();
      end
      drive(1'b0, 2'd0, 12'h000);
      cycle();
      chk("t4_ch0_held", chan_data(0), 12'h0C0);
      chk("t4_valid", out_valid, 4'b0001);

      // 5: asynchronous reset with channels 0 and 2 full.
      out_ready = 4'b0000;
      drive(1'b1, 2'd2, 12'h2E2);
      cycle();
      drive(1'b1, 2'd1, 12'h1E1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t5_async_valid", out_valid, 4'b0000);
      chk("t5_async_data", out_data, '0);
      chk("t5_rst_ready", in_ready, 1'b0);
      for (int k = 0; k < 4; k++) q[k].delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, 2'd0, 12'h000);
      out_ready = 4'b1111;
      for (int i = 0; i < 3; i++) cycle();
      chk("t5_no_stale", out_valid, 4'b0000);

`ifdef DEMUX4_STATS_EN
      // 6: counter saturation on channel 1.
      out_ready = 4'b1111;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 2'd1, WIDTH'(12'h300 + i));
         cycle();
      end
      drive(1'b0, 2'd0, 12'h000);
      cycle();
      chk("t6_cnt1", beat_cnt[1*CNT_W +: CNT_W], 4'd15);
      chk("t6_cnt0", beat_cnt[0*CNT_W +: CNT_W], 4'd0);
      chk("t6_cnt2", beat_cnt[2*CNT_W +: CNT_W], 4'd0);
      chk("t6_cnt3", beat_cnt[3*CNT_W +: CNT_W], 4'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
